bram_stream_reader: RTL
=======================

# bram_stream_reader

Drains one frame of pixels from the frame BRAM and emits it as an AXI4-Stream master toward the AXI DMA S2MM channel. It sits directly downstream of the `bram` block: it drives that memory's `ce`/`we`/`addr` and consumes its registered `o_data`. The block hides the BRAM's one-cycle read latency behind a 2-entry output buffer, so it sustains one beat per cycle and never loses data under `m_axis_tready` backpressure.

## Interface
- `ADDR_WIDTH`, 14: BRAM address width.
- `DATA_WIDTH`, 24: pixel / stream data width.
- `DEPTH`, 12672: beats per frame; addresses 0..DEPTH-1.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle frame request; ignored while `busy`=1.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last beat handshakes.
- `bram_ce`  out  1  BRAM enable; high only on read-issue cycles.
- `bram_we`  out  1  tied 0; the block never writes.
- `bram_addr`  out  ADDR_WIDTH  BRAM read address.
- `bram_rdata`  in  DATA_WIDTH  BRAM `o_data`; valid the cycle after `bram_ce`=1.
- `m_axis_tdata`  out  DATA_WIDTH  stream data.
- `m_axis_tvalid`  out  1  stream valid.
- `m_axis_tready`  in  1  stream ready.
- `m_axis_tlast`  out  1  high on beat DEPTH-1 only.

## Operation
- FSM states IDLE, RUN, DRAIN.
  - IDLE: `start`=1 -> RUN; issue counter is cleared to 0.
  - RUN: issue reads. After the read of address DEPTH-1 is issued -> DRAIN.
  - DRAIN: no issues. When the `tlast` beat handshakes -> IDLE, `done`=1 for 1 cycle.
- Read issue on a cycle when `state`=RUN, the issue counter is below DEPTH, and either `slots`<2, or `slots`=2 with an output handshake this cycle. Here `slots` = FIFO count (0..2) + in-flight flag (0/1).
- On an issue: `bram_ce`=1 and `bram_addr`=issue counter, then the counter increments.
- The in-flight flag is set on an issue and cleared the next cycle. The cycle after an issue, `bram_rdata` is pushed into the FIFO together with a last-tag (address == DEPTH-1).
- The FIFO is 2 entries. The head drives `m_axis_tdata`/`m_axis_tlast`, and `m_axis_tvalid` = FIFO non-empty. A pop happens on `tvalid && tready`.
  - Simultaneous push and pop keeps the count unchanged.
  - A push when the count is 2 with no pop cannot occur; the verification bench asserts this.
- AXI rules:
  - Once `tvalid` is high it stays high, with `tdata`/`tlast` stable, until the handshake.
  - `tvalid` never depends combinationally on `tready`.
- `start` while `busy` is ignored, with no restart. `start` in the same cycle as `done` is ignored. `start` is accepted from the next cycle onward.
- Counter width is ADDR_WIDTH+1, so the value DEPTH is representable. There is no address wrap: the address stops at DEPTH-1.

## Timing
- All outputs reset to 0: `busy`, `done`, `bram_ce`, `bram_addr`, `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tlast`. The FSM resets to IDLE, and the FIFO and in-flight flag are cleared.
- Reset mid-frame abandons the frame immediately. No `tlast` or `done` is produced, and the next `start` after reset begins again at address 0.
- Cycle timing, with `start` high in cycle 0:
  - Cycle 1: `busy`=1, `bram_ce`=1, `bram_addr`=0.
  - Cycle 2: `bram_rdata`=mem[0].
  - Cycle 3: `m_axis_tvalid`=1, `tdata`=mem[0].
- With `tready` held high, beat k appears in cycle 3+k. `tlast` is in cycle DEPTH+2, and `done` pulses with `busy` falling in cycle DEPTH+3.
- Throughput is 1 beat/cycle under continuous `tready`.
- When `tready` falls, at most 2 beats are buffered and issue stalls within 1 cycle. When `tready` rises, output resumes in the same cycle from the buffered head with no bubble.

## Test plan
- Nominal frame: DEPTH=16, mem[i]=i*0x010101, `tready`=1. Expect 16 beats 0x000000..0x0F0F0F in cycles 3..18, `tlast` only in cycle 18, `done` in cycle 19.
- Backpressure: `tready` random at 50%. Expect beat order and values identical to the nominal frame, `tdata` stable while `tvalid && !tready`, and the FIFO-overflow assertion never fires.
- Long stall: `tready`=0 from cycle 4 for 20 cycles. Expect exactly 2 reads issued beyond the accepted beats, `bram_ce` low during the stall, and resume with no lost or duplicated beat.
- Start ignored: pulse `start` at cycles 5 and 19 (the `done` cycle). Expect a single 16-beat frame and no second frame. A `start` at cycle 20 then yields a new frame from address 0.
- Reset mid-frame: assert `rst` at beat 7 for 2 cycles. Expect all outputs 0 immediately and no `tlast`/`done`. A following `start` yields a full 16-beat frame starting at mem[0].
- Full size: default DEPTH=12672, `tready`=1. Expect 12672 beats, last address 12671 with `tlast`, and `done` at cycle 12675.

Source files
------------

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - streams one frame out of the frame BRAM as an AXI4-Stream master
//
// Purpose:
//   On a start request, reads addresses 0..DEPTH-1 from the frame BRAM and
//   emits each word as one AXI4-Stream beat, tagging the final beat with
//   tlast. The BRAM has a one-cycle registered read, so a 2-entry output
//   buffer absorbs the read that is still in flight when the sink stalls.
//   This keeps one beat per cycle under continuous tready and never drops a
//   beat under backpressure.
//
// Ports:
//   clk            single clock, rising edge
//   rst            asynchronous active-high reset
//   start          one-cycle frame request, honoured only while idle
//   busy           high while a frame is being read / streamed
//   done           one-cycle pulse after the tlast beat handshakes
//   bram_ce        BRAM enable, high only on read-issue cycles
//   bram_we        BRAM write enable, always 0
//   bram_addr      BRAM read address
//   bram_rdata     BRAM read data, valid the cycle after bram_ce
//   m_axis_tdata   stream data (head of the output buffer)
//   m_axis_tvalid  stream valid (output buffer non-empty)
//   m_axis_tready  stream ready from the sink
//   m_axis_tlast   marks beat DEPTH-1

module bram_stream_reader #(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 24,
   parameter int DEPTH      = 12672
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  bram_ce,
   output logic                  bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   input  logic [DATA_WIDTH-1:0] bram_rdata,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast
);

   // The issue counter is one bit wider than the address so that the value
   // DEPTH ("all reads issued") is representable without wrapping.
   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] LAST_CNT  = CW'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                state;
   logic [CW-1:0]         issue_cnt;

   // Read in flight: issued last cycle, data arrives on bram_rdata now.
   logic                  inflight;
   logic                  inflight_last;

   // 2-entry output buffer, circular with one-bit pointers.
   logic [DATA_WIDTH-1:0] fifo_data [2];
   logic [1:0]            fifo_last;
   logic                  rd_ptr;
   logic                  wr_ptr;
   logic [1:0]            fifo_count;

   logic                  pop;
   logic                  push;
   logic                  issue;
   logic [1:0]            slots;

   // ------------------------------------------------------------------
   // Stream side: the head of the buffer is presented directly, so tvalid
   // depends only on registered state and never on tready.
   // ------------------------------------------------------------------
   assign m_axis_tvalid = (fifo_count != 2'd0);
   assign m_axis_tdata  = fifo_data[rd_ptr];
   // Gate with tvalid so a stale last-tag left in an emptied entry never
   // shows up between frames.
   assign m_axis_tlast  = m_axis_tvalid & fifo_last[rd_ptr];

   assign pop  = m_axis_tvalid & m_axis_tready;
   assign push = inflight;

   // ------------------------------------------------------------------
   // Read issue. A slot is either a filled buffer entry or a read whose
   // data has not landed yet. With both slots taken we may still issue if
   // the head leaves this cycle: the new word lands next cycle into the
   // entry the pop frees. That look-ahead is what sustains 1 beat/cycle,
   // and it is why bram_ce follows tready combinationally.
   // ------------------------------------------------------------------
   assign slots = fifo_count + {1'b0, inflight};

   always_comb begin
      issue = 1'b0;
      if ((state == RUN) && (issue_cnt < DEPTH_CNT)) begin
         issue = (slots < 2'd2) || pop;
      end
   end

   assign bram_ce = issue;
   assign bram_we = 1'b0;

   // Once every read has been issued the counter sits at DEPTH; hold the
   // address at the last valid location instead of presenting DEPTH.
   assign bram_addr = (issue_cnt < DEPTH_CNT) ? issue_cnt[ADDR_WIDTH-1:0]
                                              : LAST_CNT[ADDR_WIDTH-1:0];

   // ------------------------------------------------------------------
   // In-flight tracking and output buffer.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         fifo_data[0]  <= '0;
         fifo_data[1]  <= '0;
         fifo_last     <= 2'b00;
         rd_ptr        <= 1'b0;
         wr_ptr        <= 1'b0;
         fifo_count    <= 2'd0;
      end else begin
         inflight      <= issue;
         inflight_last <= issue && (issue_cnt == LAST_CNT);

         if (push) begin
            fifo_data[wr_ptr] <= bram_rdata;
            fifo_last[wr_ptr] <= inflight_last;
            wr_ptr            <= ~wr_ptr;
         end

         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end

         // The issue rule guarantees a push never meets a full buffer
         // without a simultaneous pop, so the count stays within 0..2.
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Frame control FSM with registered busy/done.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         issue_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // done is still high on the first idle cycle; a start there
               // belongs to the frame just finished and is dropped.
               if (start && !done) begin
                  state     <= RUN;
                  issue_cnt <= '0;
                  busy      <= 1'b1;
               end
            end

            RUN: begin
               if (issue) begin
                  issue_cnt <= issue_cnt + CW'(1);
                  if (issue_cnt == LAST_CNT) begin
                     state <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               // The tlast beat is always issued before entering DRAIN and
               // reaches the head at least two cycles after its issue, so
               // its handshake is only ever observed here.
               if (pop && m_axis_tlast) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
